// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered UART transmitter. Bytes enter a FIFO through a valid/ready
// handshake and are serialised onto the tx line as frames of one start bit,
// eight data bits (LSB first), an optional parity bit and one stop bit. Each
// bit lasts CLKS_PER_BIT clock cycles. Back-to-back frames have no idle gap.
//
// Optional feature:
//   UART_TX_PARITY_EN  Defined: a parity bit follows the data bits (11-bit
//                      frame). PARITY_ODD selects even (0) or odd (1) parity.
//                      Undefined: plain 8N1 frame; PARITY_ODD is unused.
//
// Ports:
//   clk         system clock; all state changes on the rising edge
//   reset       asynchronous, active-low reset
//   tx_data     byte to send
//   tx_valid    tx_data is valid
//   tx_ready    FIFO can accept a byte this cycle (from registered count only)
//   tx          serial line, idle high, driven from a flop
//   tx_busy     frame on the line or bytes still queued
//   fifo_count  bytes queued; excludes the byte being shifted out
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Elaboration-time parameter sanity checks.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rd_data;
  logic          push, pop, fifo_empty;

  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = tx_valid & tx_ready;
  assign rd_data    = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  // Storage has no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          frame_q;
  logic          baud_last;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          state_d = DATA;
        end
      end

      DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        if (baud_last) begin
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Loading a new byte also rewinds the bit counter.
    if (pop) begin
      shift_d = rd_data;
      bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^rd_data) ^ 1'(PARITY_ODD);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_q     <= 1'b1;
      frame_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      tx_q     <= tx_d;
      // The line lags the FSM by one cycle; frame_q follows that lag so
      // tx_busy stays high through the final stop-bit cycle on the pin.
      frame_q  <= (state_q != IDLE);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE) | frame_q | !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed and randomised bench for uart_tx_fifo with CLKS_PER_BIT=4 and
// FIFO_DEPTH=16. A line decoder recovers bytes from tx; a scoreboard of
// accepted bytes gives the expected stream. Cycle-exact waveform, latency,
// full-FIFO and reset-abort behaviour are checked against expectations
// worked out from the frame format.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int C  = 4;
  localparam int D  = 16;
  localparam int PO = 0;
  localparam int CW = $clog2(D) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          tx;
  logic          tx_busy;
  logic [CW-1:0] fifo_count;

  uart_tx_fifo #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D),
    .PARITY_ODD   (PO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         frame_errs = 0;
  int         par_errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected tx level j cycles after the accept edge of a byte sent from idle.
  function automatic logic exp_tx(input int j, input logic [7:0] b);
    int idx;
    if (j < 2) return 1'b1;
    idx = (j - 2) / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return (^b) ^ 1'(PO);
`endif
    return 1'b1;
  endfunction

  // Line decoder: samples every bit at its centre.
  initial begin : line_decoder
    int k;
    int idx;
    logic [7:0] b;
    logic act;
    act = 1'b0; k = 0; b = 8'h00; idx = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          k = 0;
          start_q.push_back(cyc);
        end
      end else begin
        k++;
        if (k % C == C / 2) begin
          idx = k / C;
          if (idx == 0) begin
            if (tx !== 1'b0) frame_errs++;
          end else if (idx <= 8) begin
            b[idx-1] = tx;
          end else if (idx == FB - 1) begin
            if (tx !== 1'b1) frame_errs++;
            rx_q.push_back(b);
            act = 1'b0;
          end else begin
            if (tx !== ((^b) ^ 1'(PO))) par_errs++;
          end
        end
      end
    end
  end

  // Present a byte and hold it until accepted; returns at the negedge after
  // the accepting edge.
  task automatic push_one(input logic [7:0] b);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", 32'(n < 2000), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(n < 5000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_rx_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk($sformatf("%s_rx_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
    chk({tag, "_frame_errs"}, 32'(frame_errs), 32'd0);
    chk({tag, "_parity_errs"}, 32'(par_errs), 32'd0);
    rx_q.delete();
    exp_q.delete();
    start_q.delete();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int mcount;
    int nxt;
    int acc;
    logic mready;
    logic pop;
    logic fire;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- single byte 0x55: exact waveform ----------------
    push_one(8'h55);
    chk("t1_count_j0", 32'(fifo_count), 32'd1);
    for (int j = 0; j <= FB * C + 4; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 1) chk("t1_count_j1", 32'(fifo_count), 32'd0);
      chk($sformatf("t1_tx_j%0d", j), 32'(tx), 32'(exp_tx(j, 8'h55)));
      chk($sformatf("t1_busy_j%0d", j), 32'(tx_busy), 32'(j <= FB * C + 1));
    end
    wait_idle("t1");
    compare_stream("t1");

    // ---------------- two bytes back to back ----------------
    push_one(8'h41);
    push_one(8'h42);
    wait_idle("t2");
    chk("t2_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2)
      chk("t2_gap", 32'(start_q[1] - start_q[0]), 32'(FB * C));
    compare_stream("t2");

    // ---------------- fill the FIFO with tx_valid held high ----------------
    mcount = 0; nxt = 0; acc = 0;
    for (int t = 0; t <= FB * C + 5; t++) begin
      chk($sformatf("t3_ready_t%0d", t), 32'(tx_ready), 32'(mcount != D));
      chk($sformatf("t3_count_t%0d", t), 32'(fifo_count), 32'(mcount));
      if (t == FB * C) chk("t3_accepts_before_pop2", 32'(acc), 32'd17);
      tx_data  = 8'(nxt);
      tx_valid = 1'b1;
      mready   = (mcount != D);
      @(negedge clk);
      // Pops happen at the edge after the first accept and at the last
      // stop cycle of the first frame.
      pop = (t == 1) || (t == FB * C + 1);
      if (mready) begin
        exp_q.push_back(8'(nxt));
        nxt++;
        acc++;
        mcount++;
      end
      if (pop) mcount--;
    end
    tx_valid = 1'b0;
    chk("t3_count_end", 32'(fifo_count), 32'(mcount));
    wait_idle("t3");
    compare_stream("t3");

    // ---------------- reset during DATA bit 3 of 0xA5 ----------------
    push_one(8'hA5);
    push_one(8'h11);
    push_one(8'h22);
    push_one(8'h33);
    // Now 3 cycles after the 0xA5 accept; data bit 3 spans j=2+4C..2+5C-1.
    repeat (2 + 4 * C + 1 - 3) @(negedge clk);
    chk("t4_tx_bit3", 32'(tx), 32'(exp_tx(2 + 4 * C + 1, 8'hA5)));
    chk("t4_count_pre", 32'(fifo_count), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("t4_async_tx", 32'(tx), 32'd1);
    chk("t4_async_count", 32'(fifo_count), 32'd0);
    chk("t4_async_busy", 32'(tx_busy), 32'd0);
    chk("t4_async_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rx_q.delete();
    start_q.delete();
    exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk($sformatf("t4_post_tx_%0d", i), 32'(tx), 32'd1);
      chk($sformatf("t4_post_busy_%0d", i), 32'(tx_busy), 32'd0);
    end
    chk("t4_no_frames", 32'(start_q.size()), 32'd0);
    compare_stream("t4");

    // ---------------- push and pop in the same cycle ----------------
    push_one(8'h3C);
    push_one(8'hC3);
    // At j=1 after the first accept; move to the cycle before the last
    // stop-bit edge of the first frame.
    repeat (FB * C - 1) @(negedge clk);
    chk("t6_count_before", 32'(fifo_count), 32'd1);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    exp_q.push_back(8'h5A);
    chk("t6_count_after", 32'(fifo_count), 32'd1);
    wait_idle("t6");
    chk("t6_frames", 32'(start_q.size()), 32'd3);
    for (int i = 1; i < start_q.size(); i++)
      chk($sformatf("t6_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(FB * C));
    compare_stream("t6");

    // ---------------- randomised traffic ----------------
    tx_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      fire = tx_valid & tx_ready;
      @(negedge clk);
      if (fire) exp_q.push_back(tx_data);
      if (fire || !tx_valid) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
      end
    end
    fire = tx_valid & tx_ready;
    @(negedge clk);
    if (fire) exp_q.push_back(tx_data);
    tx_valid = 1'b0;
    wait_idle("rnd");
    compare_stream("rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
